// File: rtl/mbist_pkg.sv
// Shared types and March C- tables for the FIFO-array BIST controller.
// Element tables are indexed by elem_e; bit n describes element Mn.
package mbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4,
        M5 = 3'd5
    } elem_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    localparam int MAX_DATA_WIDTH = 64;

    localparam logic [MAX_DATA_WIDTH-1:0] BG_ZERO = {MAX_DATA_WIDTH{1'b0}};
    localparam logic [MAX_DATA_WIDTH-1:0] BG_ONE  = {MAX_DATA_WIDTH{1'b1}};

    // 1 = element walks addresses downward
    localparam logic [7:0] ELEM_DOWN   = 8'b0011_1000;
    localparam logic [7:0] ELEM_HAS_RD = 8'b0011_1110;
    localparam logic [7:0] ELEM_HAS_WR = 8'b0001_1111;
    localparam logic [7:0] ELEM_RD_ONE = 8'b0001_0100;
    localparam logic [7:0] ELEM_WR_ONE = 8'b0000_1010;

    function automatic logic [MAX_DATA_WIDTH-1:0] bg_word(input int width, input logic one_v);
        logic [MAX_DATA_WIDTH-1:0] word_v;
        if (one_v) begin
            word_v = BG_ONE >> (MAX_DATA_WIDTH - width);
        end else begin
            word_v = BG_ZERO;
        end
        return word_v;
    endfunction

    function automatic elem_e next_elem(input elem_e e);
        elem_e n_v;
        case (e)
            M0:      n_v = M1;
            M1:      n_v = M2;
            M2:      n_v = M3;
            M3:      n_v = M4;
            M4:      n_v = M5;
            default: n_v = M0;
        endcase
        return n_v;
    endfunction

    function automatic logic elem_two_op(input elem_e e);
        return ELEM_HAS_RD[e] & ELEM_HAS_WR[e];
    endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Up/down address counter for the March walk: load-first, step, last flag.
// Holds address 0 whenever cleared so the array port idles at zero.
module mbist_addr_gen
    import mbist_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  load_down,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  down_r;
    logic                  last_s;

    // Address and direction register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr_r <= ADDR_ZERO;
            down_r <= 1'b0;
        end else if (clear) begin
            addr_r <= ADDR_ZERO;
            down_r <= 1'b0;
        end else if (load) begin
            addr_r <= load_down ? ADDR_LAST : ADDR_ZERO;
            down_r <= load_down;
        end else if (step) begin
            addr_r <= down_r ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
            down_r <= down_r;
        end else begin
            addr_r <= addr_r;
            down_r <= down_r;
        end
    end

    // Last address of the current walk depends on direction
    always_comb begin
        last_s = 1'b0;
        if (down_r) begin
            last_s = (addr_r == ADDR_ZERO);
        end else begin
            last_s = (addr_r == ADDR_LAST);
        end
    end

    assign addr = addr_r;
    assign last = last_s;

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller for the FIFO storage array; single pass/fail result.
// Optional first-failure log enabled by defining MBIST_FAIL_LOG_EN.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    output logic                  MEM_WE,
    output logic                  MEM_RE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_WDATA,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  PASSFAIL
`ifdef MBIST_FAIL_LOG_EN
    ,
    output logic                  FAIL_VALID,
    output logic [ADDR_WIDTH-1:0] FAIL_ADDR,
    output logic [DATA_WIDTH-1:0] FAIL_DATA
`endif
);

    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    state_e                state_r, state_n;
    elem_e                 elem_r, elem_n;
    logic                  phase_r, phase_n;
    op_e                   op_n_s;

    logic                  ag_clear_s, ag_load_s, ag_load_down_s, ag_step_s;
    logic [ADDR_WIDTH-1:0] ag_addr_s;
    logic                  ag_last_s;
    logic                  start_run_s;

    logic                  mem_we_r, mem_re_r, busy_r, done_r, passfail_r;
    logic [DATA_WIDTH-1:0] mem_wdata_r, rd_exp_r;
    logic                  we_n, re_n, busy_n, done_n;
    logic [DATA_WIDTH-1:0] wdata_n, exp_n;

    logic                  cmp_valid_r;
    logic [DATA_WIDTH-1:0] cmp_exp_r;
    logic                  mismatch_s;

    mbist_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_addr_gen (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .clear     (ag_clear_s),
        .load      (ag_load_s),
        .load_down (ag_load_down_s),
        .step      (ag_step_s),
        .addr      (ag_addr_s),
        .last      (ag_last_s)
    );

    // Next state and March sequencing; a two-op element stays on one address for read then write
    always_comb begin
        state_n        = state_r;
        elem_n         = elem_r;
        phase_n        = phase_r;
        ag_clear_s     = 1'b0;
        ag_load_s      = 1'b0;
        ag_load_down_s = 1'b0;
        ag_step_s      = 1'b0;
        start_run_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_n        = ST_RUN;
                    elem_n         = M0;
                    phase_n        = 1'b0;
                    ag_load_s      = 1'b1;
                    ag_load_down_s = ELEM_DOWN[M0];
                    start_run_s    = 1'b1;
                end else begin
                    ag_clear_s = 1'b1;
                end
            end
            ST_RUN: begin
                if (!phase_r && elem_two_op(elem_r)) begin
                    phase_n = 1'b1;
                end else if (!ag_last_s) begin
                    phase_n   = 1'b0;
                    ag_step_s = 1'b1;
                end else if (elem_r == M5) begin
                    state_n    = ST_DRAIN;
                    phase_n    = 1'b0;
                    ag_clear_s = 1'b1;
                end else begin
                    elem_n         = next_elem(elem_r);
                    phase_n        = 1'b0;
                    ag_load_s      = 1'b1;
                    ag_load_down_s = ELEM_DOWN[next_elem(elem_r)];
                end
            end
            ST_DRAIN: begin
                state_n    = ST_DONE;
                ag_clear_s = 1'b1;
            end
            default: begin
                state_n    = ST_IDLE;
                ag_clear_s = 1'b1;
            end
        endcase
    end

    // Decode the operation issued next cycle so the array port is driven from flops
    always_comb begin
        we_n    = 1'b0;
        re_n    = 1'b0;
        wdata_n = DATA_ZERO;
        exp_n   = DATA_ZERO;
        if (!phase_n && ELEM_HAS_RD[elem_n]) begin
            op_n_s = OP_READ;
        end else begin
            op_n_s = OP_WRITE;
        end
        if (state_n == ST_RUN) begin
            if (op_n_s == OP_WRITE) begin
                we_n    = 1'b1;
                wdata_n = DATA_WIDTH'(bg_word(DATA_WIDTH, ELEM_WR_ONE[elem_n]));
            end else begin
                re_n  = 1'b1;
                exp_n = DATA_WIDTH'(bg_word(DATA_WIDTH, ELEM_RD_ONE[elem_n]));
            end
        end else begin
            we_n = 1'b0;
            re_n = 1'b0;
        end
        busy_n = (state_n == ST_RUN) || (state_n == ST_DRAIN);
        done_n = (state_n == ST_DONE);
    end

    // Sequencer state and registered array/status outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            elem_r      <= M0;
            phase_r     <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_re_r    <= 1'b0;
            mem_wdata_r <= DATA_ZERO;
            rd_exp_r    <= DATA_ZERO;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            elem_r      <= elem_n;
            phase_r     <= phase_n;
            mem_we_r    <= we_n;
            mem_re_r    <= re_n;
            mem_wdata_r <= wdata_n;
            rd_exp_r    <= exp_n;
            busy_r      <= busy_n;
            done_r      <= done_n;
        end
    end

    // Expected word travels one stage behind MEM_RE to meet the returning read data
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cmp_valid_r <= 1'b0;
            cmp_exp_r   <= DATA_ZERO;
        end else begin
            cmp_valid_r <= mem_re_r;
            cmp_exp_r   <= rd_exp_r;
        end
    end

    assign mismatch_s = cmp_valid_r && (MEM_RDATA != cmp_exp_r);

    // Sticky pass/fail, re-armed on every launch
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            passfail_r <= 1'b0;
        end else if (start_run_s) begin
            passfail_r <= 1'b1;
        end else if (mismatch_s) begin
            passfail_r <= 1'b0;
        end else begin
            passfail_r <= passfail_r;
        end
    end

`ifdef MBIST_FAIL_LOG_EN
    logic [ADDR_WIDTH-1:0] cmp_addr_r;
    logic                  fail_valid_r;
    logic [ADDR_WIDTH-1:0] fail_addr_r;
    logic [DATA_WIDTH-1:0] fail_data_r;

    // First-failure log; later mismatches leave it untouched
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cmp_addr_r   <= {ADDR_WIDTH{1'b0}};
            fail_valid_r <= 1'b0;
            fail_addr_r  <= {ADDR_WIDTH{1'b0}};
            fail_data_r  <= DATA_ZERO;
        end else begin
            cmp_addr_r <= ag_addr_s;
            if (start_run_s) begin
                fail_valid_r <= 1'b0;
                fail_addr_r  <= {ADDR_WIDTH{1'b0}};
                fail_data_r  <= DATA_ZERO;
            end else if (mismatch_s && !fail_valid_r) begin
                fail_valid_r <= 1'b1;
                fail_addr_r  <= cmp_addr_r;
                fail_data_r  <= MEM_RDATA;
            end else begin
                fail_valid_r <= fail_valid_r;
                fail_addr_r  <= fail_addr_r;
                fail_data_r  <= fail_data_r;
            end
        end
    end

    assign FAIL_VALID = fail_valid_r;
    assign FAIL_ADDR  = fail_addr_r;
    assign FAIL_DATA  = fail_data_r;
`endif

    assign MEM_WE    = mem_we_r;
    assign MEM_RE    = mem_re_r;
    assign MEM_ADDR  = ag_addr_s;
    assign MEM_WDATA = mem_wdata_r;
    assign BUSY      = busy_r;
    assign DONE      = done_r;
    assign PASSFAIL  = passfail_r;

endmodule

// File: doc/mbist_march_ctrl.md
# mbist_march_ctrl

Memory BIST controller that runs a March C- test on the FIFO storage array and reports a single pass/fail result. It drives the array's write and read ports directly and generates the data background and address order. It compares each read against the expected value one cycle after the read is issued. It sits between the FIFO core and the test-mode mux, and owns the array only while BUSY is high.

## Interface
- DATA_WIDTH, 8: array word width.
- ADDR_WIDTH, 4: array address width.
- DEPTH, 16: number of words tested. Must satisfy 2 ≤ DEPTH ≤ 2^ADDR_WIDTH. Need not be a power of two.

- CLK  in  1  single clock; all logic is on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  level, sampled at each edge. Launches a test when the controller is idle or done.
- MEM_WE  out  1  array write enable.
- MEM_RE  out  1  array read enable.
- MEM_ADDR  out  ADDR_WIDTH  array address.
- MEM_WDATA  out  DATA_WIDTH  array write data.
- MEM_RDATA  in  DATA_WIDTH  array read data, valid one cycle after MEM_RE.
- BUSY  out  1  high while the test owns the array.
- DONE  out  1  high once the result is final.
- PASSFAIL  out  1  1 = no mismatch so far or final pass; 0 = fail.
- FAIL_VALID, FAIL_ADDR, FAIL_DATA  out  1 / ADDR_WIDTH / DATA_WIDTH  present only with the macro (see Configuration).

## Operation
- All outputs are registered. Reset value of every output is 0.
- States:
  - IDLE: waits for START.
  - RUN: executes the March elements.
  - DRAIN: one cycle, waits for the final compare.
  - DONE: holds the result.
- Transitions:
  - IDLE→RUN on START=1.
  - RUN→DRAIN after the last operation of M5.
  - DRAIN→DONE unconditionally.
  - DONE→RUN on START=1.
  - DONE stays in DONE while START=0.
- START is ignored in RUN and DRAIN.
- Entering RUN sets PASSFAIL=1 and clears DONE and the fail log.
- March elements (0 = all-zeros word, 1 = all-ones word):
  - M0 up (w0)
  - M1 up (r0,w1)
  - M2 up (r1,w0)
  - M3 down (r0,w1)
  - M4 down (r1,w0)
  - M5 down (r0)
- Address order:
  - "up" counts 0..DEPTH-1.
  - "down" counts DEPTH-1..0.
  - An element starts at its first address in the cycle after the previous element's last operation; there are no idle cycles between elements.
- Exactly one operation per cycle. MEM_WE and MEM_RE are never both high. In two-op elements the read and the write hit the same address on consecutive cycles.
- When the array is not in use: MEM_WE=MEM_RE=0, and MEM_ADDR and MEM_WDATA hold 0.
- Compare:
  - The expected word is pipelined one stage alongside MEM_RE.
  - A mismatch of MEM_RDATA against the expected word clears PASSFAIL.
  - PASSFAIL is sticky low until the next START.

## Timing
- START sampled high at edge T: BUSY=1 and the first M0 write (address 0) are visible in the cycle after T.
- Read issued in cycle k: MEM_RDATA is sampled at the end of cycle k+1, and PASSFAIL reflects that compare from cycle k+2.
- Operation cycles = 10·DEPTH, plus 1 DRAIN cycle, so BUSY is high for 10·DEPTH+1 cycles.
- DONE rises, and BUSY falls, in the same cycle; PASSFAIL is final in that cycle.
- Reset mid-test: all outputs return to 0 immediately (asynchronous), the state goes to IDLE, and no further array access occurs.
- START held high through DONE restarts the test on the first edge in DONE.

## Configuration
- Macro: MBIST_FAIL_LOG_EN.
- With the macro defined:
  - On the first mismatch, FAIL_VALID=1 and FAIL_ADDR/FAIL_DATA capture the read address and MEM_RDATA.
  - Later mismatches do not overwrite the log.
  - The log is cleared on START and on reset.
- Without the macro: the three ports and their registers are absent. PASSFAIL behaviour is identical in both cases.

## Structure
- Package mbist_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the March element enum M0..M5;
  - the op encoding (READ, WRITE);
  - the per-element direction and data tables;
  - the background constants BG_ZERO and BG_ONE, sized by function of DATA_WIDTH.
- Sub-module mbist_addr_gen:
  - up/down address counter with load-first, step, and a last-address flag;
  - DEPTH- and direction-aware.

## Test plan
- Fault-free array model, DEPTH=16, DATA_WIDTH=8, START pulse → BUSY high 161 cycles; operation sequence matches M0..M5 exactly; DONE=1, PASSFAIL=1.
- Bit 0 of address 5 stuck-at-1 → PASSFAIL falls two cycles after the M1 read of address 5; final PASSFAIL=0; log gives FAIL_ADDR=5, FAIL_DATA=0x01.
- DEPTH=5, ADDR_WIDTH=4 → addresses never exceed 4; down elements start at 4; BUSY high 51 cycles.
- RST_N pulsed low during M3 → all outputs 0 at once; after release, START launches a clean full run that passes.
- START toggled during RUN → no effect on sequence or cycle count. START held high → back-to-back runs with one DONE cycle between them.
- Address 9 faulty only on write-1 (reads back 0x00) → first mismatch at M2 read of address 9, FAIL_DATA=0x00; PASSFAIL stays 0 through DONE.
